// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle multiply/divide unit with architectural HI/LO.
// A shift-add multiplier and a restoring divider run one bit per cycle
// through the state sequence IDLE -> PREP -> CALC -> FIX.
// mthi/mtlo are serviced directly from IDLE.
// Optional feature macro: MULDIV_DIV_EN. When it is defined, the divider is
// built. When it is undefined, div/divu complete at once with flag_dz set.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_dz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;
  state_t state_reg, state_next;

  logic                 op_valid;
  logic                 accept;
  logic                 accept_calc;
  logic                 is_unsigned_reg;
  logic                 sign_q_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     opnd_reg;   // |a| for multiply, |b| for divide
  logic [2*WIDTH-1:0]   acc_reg;    // product accumulator / quotient shifter
  logic [CW-1:0]        cnt_reg;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;
  logic                 res_neg;
`ifdef MULDIV_DIV_EN
  logic                 is_div_reg;
  logic                 sign_r_reg;
  logic [WIDTH-1:0]     rem_reg;    // partial remainder, always < divisor
  logic [WIDTH:0]       div_shift;  // WIDTH+1-bit trial value
  logic                 div_ge;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rmd;
  logic                 dz;
`endif

  // Request decode: only an idle unit with a defined op accepts a start.
  always_comb begin
    op_valid = (op <= OP_MTLO);
    accept   = start && (state_reg == IDLE) && op_valid;
`ifdef MULDIV_DIV_EN
    accept_calc = accept && !op[2];
`else
    accept_calc = accept && (op[2:1] == 2'b00);
`endif
  end

  // Sign handling and the per-cycle arithmetic steps.
  always_comb begin
    a_neg    = !is_unsigned_reg && a_reg[WIDTH-1];
    b_neg    = !is_unsigned_reg && b_reg[WIDTH-1];
    mag_a    = a_neg ? -a_reg : a_reg;
    mag_b    = b_neg ? -b_reg : b_reg;
    // Add the multiplicand when the current multiplier bit is set, then
    // shift the whole accumulator right by one.
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
               (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_step = {mul_sum, acc_reg[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {rem_reg, acc_reg[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
`endif
  end

  // Final sign fix-up and result selection used on the FIX edge.
  always_comb begin
    prod    = sign_q_reg ? -acc_reg : acc_reg;
    res_hi  = prod[2*WIDTH-1:WIDTH];
    res_lo  = prod[WIDTH-1:0];
    res_neg = prod[2*WIDTH-1];
`ifdef MULDIV_DIV_EN
    quo = sign_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rmd = sign_r_reg ? -rem_reg : rem_reg;
    dz  = (b_reg == '0);
    if (is_div_reg) begin
      // Divide by zero reports all-ones quotient and the raw dividend.
      if (dz) begin
        res_hi = a_reg;
        res_lo = '1;
      end else begin
        res_hi = rmd;
        res_lo = quo;
      end
      res_neg = res_lo[WIDTH-1];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: WIDTH iterations in CALC, one cycle each in PREP and FIX.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept_calc) state_next = PREP;
      PREP:    state_next = CALC;
      CALC:    if (cnt_reg == LAST_ITER) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, architectural registers and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      hi              <= '0;
      lo              <= '0;
      flag_zero       <= 1'b0;
      flag_neg        <= 1'b0;
      flag_dz         <= 1'b0;
      is_unsigned_reg <= 1'b0;
      sign_q_reg      <= 1'b0;
      a_reg           <= '0;
      b_reg           <= '0;
      opnd_reg        <= '0;
      acc_reg         <= '0;
      cnt_reg         <= '0;
`ifdef MULDIV_DIV_EN
      is_div_reg      <= 1'b0;
      sign_r_reg      <= 1'b0;
      rem_reg         <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg           <= a;
            b_reg           <= b;
            is_unsigned_reg <= op[0];
`ifdef MULDIV_DIV_EN
            is_div_reg      <= op[1];
`endif
            case (op)
              OP_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: begin
`ifdef MULDIV_DIV_EN
                busy <= 1'b1;
`else
                // Without a divider, div/divu finish at once and report dz.
                if (accept_calc) begin
                  busy <= 1'b1;
                end else begin
                  done    <= 1'b1;
                  flag_dz <= 1'b1;
                end
`endif
              end
            endcase
          end
        end
        PREP: begin
          sign_q_reg <= a_neg ^ b_neg;
          cnt_reg    <= '0;
`ifdef MULDIV_DIV_EN
          sign_r_reg <= a_neg;
          rem_reg    <= '0;
          if (is_div_reg) begin
            acc_reg  <= {{WIDTH{1'b0}}, mag_a};
            opnd_reg <= mag_b;
          end else begin
            acc_reg  <= {{WIDTH{1'b0}}, mag_b};
            opnd_reg <= mag_a;
          end
`else
          acc_reg  <= {{WIDTH{1'b0}}, mag_b};
          opnd_reg <= mag_a;
`endif
        end
        CALC: begin
          cnt_reg <= cnt_reg + CW'(1);
`ifdef MULDIV_DIV_EN
          if (is_div_reg) begin
            // Restoring step: keep the difference only when it is non-negative.
            rem_reg <= WIDTH'(div_shift - (div_ge ? {1'b0, opnd_reg} : '0));
            acc_reg[WIDTH-1:0] <= {acc_reg[WIDTH-2:0], div_ge};
          end else begin
            acc_reg <= mul_step;
          end
`else
          acc_reg <= mul_step;
`endif
        end
        FIX: begin
          hi        <= res_hi;
          lo        <= res_lo;
          flag_zero <= ({res_hi, res_lo} == '0);
          flag_neg  <= res_neg;
`ifdef MULDIV_DIV_EN
          flag_dz   <= is_div_reg && dz;
`else
          flag_dz   <= 1'b0;
`endif
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed testbench for alu_muldiv_seq (WIDTH=32).
// Expected results are hand-computed. The division checks follow MULDIV_DIV_EN.
module tb_alu_muldiv_seq;

  localparam int WIDTH = 32;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_RSVD  = 3'b110;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             flag_zero;
  logic             flag_neg;
  logic             flag_dz;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  alu_muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .flag_dz   (flag_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request at a negedge and wait for done. lat is the number of
  // rising edges after the accept edge before done is seen. When inj >= 0,
  // a competing multu start is driven at that point of the wait.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int inj, output int lat, output logic busy_first);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    busy_first = busy;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == inj) begin
        start = 1'b1; op = OP_MULTU; a = '1; b = '1;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    $display("op=%b a=%h b=%h lat=%0d hi=%h lo=%h z=%b n=%b dz=%b",
             o, av, bv, lat, hi, lo, flag_zero, flag_neg, flag_dz);
  endtask

  int   lat;
  logic bf;
  logic seen;
  logic [31:0] exp_lo;

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    step();
    step();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", flag_zero, 0);
    check("rst_neg", flag_neg, 0);
    check("rst_dz", flag_dz, 0);
    rst = 1'b0;
    step();

    // Signed multiply: -3 * 7 = -21.
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h7, -1, lat, bf);
    check("mult_lat", lat, 34);
    check("mult_busy_first", bf, 1);
    check("mult_busy_done", busy, 0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    check("mult_neg", flag_neg, 1);
    check("mult_zero", flag_zero, 0);
    step();
    check("mult_done_pulse", done, 0);

    // Unsigned multiply of the maximum values.
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, bf);
    check("multu_lat", lat, 34);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    check("multu_neg", flag_neg, 1);
    step();

`ifdef MULDIV_DIV_EN
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, -1, lat, bf);
    check("div_lat", lat, 34);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_dz", flag_dz, 0);
    step();
    run_op(OP_DIVU, 32'h7, 32'h2, -1, lat, bf);
    check("divu_lo", lo, 32'h3);
    check("divu_hi", hi, 32'h1);
    check("divu_neg", flag_neg, 0);
    step();
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, lat, bf);
    check("divmn_lo", lo, 32'h80000000);
    check("divmn_hi", hi, 32'h0);
    check("divmn_dz", flag_dz, 0);
    check("divmn_neg", flag_neg, 1);
    step();
    run_op(OP_DIV, 32'h12345678, 32'h0, -1, lat, bf);
    check("divz_lat", lat, 34);
    check("divz_lo", lo, 32'hFFFFFFFF);
    check("divz_hi", hi, 32'h12345678);
    check("divz_dz", flag_dz, 1);
    exp_lo = 32'hFFFFFFFF;
`else
    run_op(OP_DIV, 32'h12345678, 32'h0, -1, lat, bf);
    check("divz_lat", lat, 0);
    check("divz_busy", bf, 0);
    check("divz_lo", lo, 32'h00000001);
    check("divz_hi", hi, 32'hFFFFFFFE);
    check("divz_dz", flag_dz, 1);
    step();
    run_op(OP_DIVU, 32'h7, 32'h2, -1, lat, bf);
    check("divu_lat", lat, 0);
    check("divu_lo", lo, 32'h00000001);
    check("divu_dz", flag_dz, 1);
    exp_lo = 32'h00000001;
`endif
    step();

    // mthi / mtlo complete in the cycle after accept and leave flags alone.
    run_op(OP_MTHI, 32'hAA, 32'h0, -1, lat, bf);
    check("mthi_lat", lat, 0);
    check("mthi_busy", bf, 0);
    check("mthi_hi", hi, 32'hAA);
    check("mthi_lo", lo, exp_lo);
    check("mthi_dz", flag_dz, 1);
    step();
    run_op(OP_MTLO, 32'h55, 32'h0, -1, lat, bf);
    check("mtlo_lat", lat, 0);
    check("mtlo_lo", lo, 32'h55);
    check("mtlo_hi", hi, 32'hAA);
    step();

    // Reserved op is ignored entirely.
    start = 1'b1; op = OP_RSVD; a = 32'h1234; b = 32'h5;
    step();
    start = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen = seen | done | busy;
      step();
    end
    check("rsvd_activity", seen, 0);
    check("rsvd_hi", hi, 32'hAA);
    check("rsvd_lo", lo, 32'h55);

    // Zero product sets flag_zero.
    run_op(OP_MULT, 32'h0, 32'h12345, -1, lat, bf);
    check("mz_lo", lo, 32'h0);
    check("mz_hi", hi, 32'h0);
    check("mz_zero", flag_zero, 1);
    check("mz_neg", flag_neg, 0);
    step();

    // A start while busy is ignored; a start in the done cycle is accepted.
    run_op(OP_MULT, 32'h5, 32'h6, 10, lat, bf);
    check("ign_lat", lat, 34);
    check("ign_lo", lo, 32'h1E);
    check("ign_hi", hi, 32'h0);
    check("ign_busy_done", busy, 0);
    run_op(OP_MULTU, 32'h3, 32'h4, -1, lat, bf);
    check("b2b_lat", lat, 34);
    check("b2b_busy_first", bf, 1);
    check("b2b_lo", lo, 32'hC);
    step();
    check("b2b_done_pulse", done, 0);
    check("b2b_idle", busy, 0);

    // Asynchronous reset in the middle of an operation.
    start = 1'b1;
`ifdef MULDIV_DIV_EN
    op = OP_DIV;
`else
    op = OP_MULT;
`endif
    a = 32'hFFFFFFF9; b = 32'h2;
    step();
    start = 1'b0;
    repeat (19) step();
    #2 rst = 1'b1;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_dz", flag_dz, 0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      seen = seen | done | busy;
      step();
    end
    check("arst_no_done", seen, 0);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'h7, -1, lat, bf);
    check("post_lat", lat, 34);
    check("post_hi", hi, 32'hFFFFFFFF);
    check("post_lo", lo, 32'hFFFFFFEB);
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS-style datapath. It sits beside the single-cycle ALU and takes over the mult/multu/div/divu/mthi/mtlo work. It uses a start/busy/done handshake, so that a WIDTH-bit shift-add multiplier and a restoring divider replace the combinational 64-bit product and quotient paths. Results persist in HI/LO until the next operation or reset.

## Interface
- WIDTH, 32: operand width and HI/LO width; any value ≥ 4.
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled on the rising edge of clk
- op  in  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 11x is reserved
- a  in  WIDTH  multiplicand / dividend / mthi-mtlo source
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high while an arithmetic operation is in flight
- done  out  1  one-cycle completion pulse
- hi  out  WIDTH  HI register (product high half / remainder)
- lo  out  WIDTH  LO register (product low half / quotient)
- flag_zero  out  1  set when {hi,lo} == 0 after the last arithmetic op
- flag_neg  out  1  set when hi[WIDTH-1] == 1 after mult, or lo[WIDTH-1] == 1 after div
- flag_dz  out  1  set when the last div/divu had b == 0

## Operation
- FSM states:
  - IDLE → PREP → CALC → FIX → IDLE.
- Accept:
  - start=1 with state IDLE and a valid op.
  - a, b and op are latched at the accept edge; later input changes are ignored.
- Ignored requests:
  - start while busy.
  - start with a reserved op.
  - In both cases there is no state change and no done.
- mthi/mtlo:
  - Write a into hi/lo on the accept edge.
  - done pulses in the following cycle.
  - The FSM stays in IDLE, busy stays 0, and flags are unchanged.
- PREP:
  - Signed ops (mult, div) take magnitudes of a and b and record the result sign.
  - The quotient/product sign is a_sign XOR b_sign.
  - The remainder sign is a_sign.
  - Unsigned ops pass a and b through.
- CALC:
  - Exactly WIDTH iterations, counted by a $clog2(WIDTH+1)-bit counter.
  - Multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle; the partial remainder is WIDTH+1 bits.
- FIX:
  - Two's-complement the product, quotient and remainder as recorded in PREP.
  - Write hi/lo, update the flags, pulse done.
- Division semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives quotient = most-negative and remainder = 0, with no flag.
- Divide by zero:
  - lo = all ones, hi = a, flag_dz=1.
  - Still takes the full latency.
- Reset values: hi=0, lo=0, busy=0, done=0, all flags 0, FSM in IDLE.
- Reset mid-operation aborts the operation; no done is produced.

## Timing
- Arithmetic latency:
  - Accept at edge 0, done=1 in the cycle after edge WIDTH+2.
  - That is 34 cycles for WIDTH=32.
- busy:
  - High from the cycle after edge 0 through the cycle before done.
  - busy=0 in the done cycle, so a new start in the done cycle is accepted (back-to-back).
- hi/lo/flags change only on the done edge (or the mthi/mtlo accept edge); they are stable otherwise.
- done is registered and lasts exactly one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MULDIV_DIV_EN:
  - Defined: div/divu are implemented as described above.
  - Undefined: the divider datapath is removed. div/divu are accepted but take no arithmetic path: done pulses the cycle after the accept edge, hi/lo are unchanged, and flag_dz=1. mult/multu/mthi/mtlo are unaffected.

## Test plan
- mult a=−3 (FFFFFFFD), b=7 → done 34 cycles after accept; hi=FFFFFFFF, lo=FFFFFFEB, flag_neg=1, flag_zero=0.
- multu a=b=FFFFFFFF → hi=FFFFFFFE, lo=00000001, flag_neg=1.
- div a=−7, b=2 → lo=FFFFFFFD, hi=FFFFFFFF. Then divu a=7, b=2 → lo=3, hi=1. Then div a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- div a=12345678, b=0 → lo=FFFFFFFF, hi=12345678, flag_dz=1, latency 34. With MULDIV_DIV_EN undefined: done after 1 cycle, hi/lo unchanged, flag_dz=1.
- Busy and back-to-back handling:
  - mult in progress, start with op=multu at cycle 10 → ignored; a single done at cycle 34.
  - start asserted in the done cycle → accepted; second done 34 cycles later.
  - mthi a=AA → hi=AA, done one cycle after accept, busy stays 0.
- Reset handling:
  - Assert rst asynchronously at cycle 20 of a div → immediate hi=lo=0, busy=0, no done.
  - After release, a new mult completes normally.
